// File: rtl/rr_arbiter4.sv
// Four-queue round-robin arbiter with per-turn burst weight, feeding the demux select path.
// Drains FWFT FIFOs one word per cycle; stall freezes arbitration for the cycle it is sampled.
module rr_arbiter4 #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned BURST  = 1,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic              stall,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        select,
    output logic              valid_out
);

    // One extra bit so BURST == 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(BURST);

    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt;
    logic              grant;
    logic [1:0]        g;
    logic [1:0]        cand;
    logic [CNT_W:0]    cnt_inc;
    logic [DATA_W-1:0] din [4];

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign din[2] = data_in_2;
    assign din[3] = data_in_3;

    always_comb begin
        grant = 1'b0;
        g     = ptr;
        cand  = ptr;
        if (reset && !stall) begin
            if (!empty[ptr] && ({1'b0, cnt} < BURST_LIM)) begin
                grant = 1'b1;
                g     = ptr;
            end else begin
                for (int unsigned k = 1; k < 4; k++) begin
                    cand = ptr + 2'(k);
                    if (!grant && !empty[cand]) begin
                        grant = 1'b1;
                        g     = cand;
                    end
                end
            end
        end
    end

    assign pop     = grant ? (4'b0001 << g) : '0;
    assign cnt_inc = (g == ptr) ? ({1'b0, cnt} + (CNT_W+1)'(1)) : (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            cnt       <= '0;
            data_out  <= '0;
            select    <= '0;
            valid_out <= 1'b0;
        end else if (grant) begin
            data_out  <= din[g];
            select    <= g;
            valid_out <= 1'b1;
            // A completed turn hands the pointer straight to the next queue.
            if (cnt_inc == BURST_LIM) begin
                ptr <= g + 2'd1;
                cnt <= '0;
            end else begin
                ptr <= g;
                cnt <= cnt_inc[CNT_W-1:0];
            end
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (BURST 1, 3, 4), one active at a time,
// fed from bench-side FIFO queues and checked every cycle against a turn-based model.
module tb_rr_arbiter4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] emp_i  [3];
    logic [9:0] d_v    [4];
    logic [3:0] pop_w  [3];
    logic [9:0] dout_w [3];
    logic [1:0] sel_w  [3];
    logic       vld_w  [3];

    int act = 0;
    int burst_of [3] = '{1, 3, 4};

    logic [9:0] fq [4][$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [1:0] lsel [$];
    logic [9:0] ldat [$];
    int         lcyc [$];
    logic [3:0] pop_seen = '0;

    int         m_hold  = 0;
    int         m_used  = 0;
    logic       m_valid = 1'b0;
    logic [9:0] m_data  = '0;
    logic [1:0] m_sel   = '0;
    int         mg;
    int         eg;
    logic [3:0] ep;

    int         rot_s [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [9:0] rot_d [8] = '{10'h000, 10'h010, 10'h020, 10'h030, 10'h001, 10'h011, 10'h021, 10'h031};
    int         skp_s [8] = '{1, 3, 1, 3, 0, 0, 0, 0};
    logic [9:0] skp_d [8] = '{10'h010, 10'h030, 10'h011, 10'h031, 10'h000, 10'h000, 10'h000, 10'h000};
    int         bur_s [8] = '{0, 0, 0, 2, 2, 0, 0, 0};
    logic [9:0] bur_d [8] = '{10'h100, 10'h101, 10'h102, 10'h120, 10'h121, 10'h103, 10'h104, 10'h000};
    int         stl_s [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    logic [9:0] stl_d [8] = '{10'h011, 10'h021, 10'h031, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    int         rst_s [8] = '{0, 0, 2, 2, 2, 0, 0, 0};
    logic [9:0] rst_d [8] = '{10'h300, 10'h301, 10'h202, 10'h203, 10'h204, 10'h000, 10'h000, 10'h000};

    rr_arbiter4 #(.DATA_W(10), .BURST(1), .CNT_W(3)) u_b1 (
        .clk(clk), .reset(reset), .empty(emp_i[0]),
        .data_in_0(d_v[0]), .data_in_1(d_v[1]), .data_in_2(d_v[2]), .data_in_3(d_v[3]),
        .stall(stall), .pop(pop_w[0]), .data_out(dout_w[0]), .select(sel_w[0]), .valid_out(vld_w[0])
    );

    rr_arbiter4 #(.DATA_W(10), .BURST(3), .CNT_W(3)) u_b3 (
        .clk(clk), .reset(reset), .empty(emp_i[1]),
        .data_in_0(d_v[0]), .data_in_1(d_v[1]), .data_in_2(d_v[2]), .data_in_3(d_v[3]),
        .stall(stall), .pop(pop_w[1]), .data_out(dout_w[1]), .select(sel_w[1]), .valid_out(vld_w[1])
    );

    rr_arbiter4 #(.DATA_W(10), .BURST(4), .CNT_W(3)) u_b4 (
        .clk(clk), .reset(reset), .empty(emp_i[2]),
        .data_in_0(d_v[0]), .data_in_1(d_v[1]), .data_in_2(d_v[2]), .data_in_3(d_v[3]),
        .stall(stall), .pop(pop_w[2]), .data_out(dout_w[2]), .select(sel_w[2]), .valid_out(vld_w[2])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic refresh();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            e[i]   = (fq[i].size() == 0);
            d_v[i] = (fq[i].size() != 0) ? fq[i][0] : 10'h000;
        end
        for (int k = 0; k < 3; k++) emp_i[k] = (k == act) ? e : 4'hF;
    endtask

    // Turn model: the holder keeps priority until it has used its burst, then
    // the first non-empty queue in circular order after it takes a fresh turn.
    function automatic int pick(input int hold, input int used, input int burst, input logic [3:0] emp);
        for (int k = 0; k < 4; k++) begin
            int q;
            q = (hold + k) % 4;
            if (!(k == 0 && used >= burst) && !emp[q]) return q;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hold  = 0;
            m_used  = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = '0;
        end else begin
            mg = stall ? -1 : pick(m_hold, m_used, burst_of[act], emp_i[act]);
            if (mg < 0) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_data  = d_v[mg];
                m_sel   = 2'(mg);
                m_used  = (mg == m_hold) ? m_used + 1 : 1;
                m_hold  = mg;
                if (m_used == burst_of[act]) begin
                    m_hold = (mg + 1) % 4;
                    m_used = 0;
                end
                #1;
                void'(fq[mg].pop_front());
                refresh();
            end
        end
    end

    always @(negedge clk) begin
        eg = (reset && !stall) ? pick(m_hold, m_used, burst_of[act], emp_i[act]) : -1;
        ep = (eg < 0) ? 4'b0000 : 4'(1 << eg);
        chk("pop", 32'(pop_w[act]), 32'(ep));
        chk("valid_out", 32'(vld_w[act]), 32'(m_valid));
        chk("data_out", 32'(dout_w[act]), 32'(m_data));
        chk("select", 32'(sel_w[act]), 32'(m_sel));
        pop_seen = pop_seen | pop_w[act];
        if (vld_w[act]) begin
            lsel.push_back(sel_w[act]);
            ldat.push_back(dout_w[act]);
            lcyc.push_back(cyc);
        end
    end

    task automatic clear_logs();
        lsel.delete();
        ldat.delete();
        lcyc.delete();
        pop_seen = '0;
    endtask

    task automatic start(input int inst);
        @(posedge clk);
        #3;
        reset = 1'b0;
        stall = 1'b0;
        act   = inst;
        for (int i = 0; i < 4; i++) fq[i].delete();
        refresh();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic check_log(input string nm, input int n, input int es [8], input logic [9:0] ed [8]);
        chk({nm, "_count"}, 32'(lsel.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < lsel.size()) begin
                chk($sformatf("%s_sel[%0d]", nm, k), 32'(lsel[k]), 32'(es[k]));
                chk($sformatf("%s_data[%0d]", nm, k), 32'(ldat[k]), 32'(ed[k]));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        refresh();

        // Reset with all queues full, then strict rotation with BURST=1.
        start(0);
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 2; w++) fq[i].push_back(10'(i * 16 + w));
        refresh();
        @(negedge clk);
        #1;
        chk("rst_pop", 32'(pop_w[0]), 32'h0);
        chk("rst_valid", 32'(vld_w[0]), 32'h0);
        chk("rst_data", 32'(dout_w[0]), 32'h000);
        chk("rst_select", 32'(sel_w[0]), 32'h0);
        clear_logs();
        release_rst();
        #1;
        chk("first_pop_after_release", 32'(pop_w[0]), 32'b0001);
        run(10);
        check_log("rotation", 8, rot_s, rot_d);
        if (lcyc.size() == 8) chk("rotation_contiguous", 32'(lcyc[7] - lcyc[0]), 32'd7);

        // Skip empty queues.
        start(0);
        for (int w = 0; w < 2; w++) begin
            fq[1].push_back(10'(16 + w));
            fq[3].push_back(10'(48 + w));
        end
        refresh();
        clear_logs();
        release_rst();
        run(8);
        check_log("skip", 4, skp_s, skp_d);
        chk("skip_no_pop_0_2", 32'(pop_seen & 4'b0101), 32'h0);

        // Burst of three.
        start(1);
        for (int w = 0; w < 5; w++) fq[0].push_back(10'(10'h100 + w));
        for (int w = 0; w < 2; w++) fq[2].push_back(10'(10'h120 + w));
        refresh();
        clear_logs();
        release_rst();
        run(10);
        check_log("burst", 7, bur_s, bur_d);

        // Stall for three cycles after a grant of queue 1.
        start(0);
        fq[1].push_back(10'h011);
        fq[2].push_back(10'h021);
        fq[3].push_back(10'h031);
        refresh();
        clear_logs();
        release_rst();
        @(posedge clk);
        #1;
        chk("stall_pre_valid", 32'(vld_w[0]), 32'h1);
        chk("stall_pre_select", 32'(sel_w[0]), 32'h1);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall_pop[%0d]", s), 32'(pop_w[0]), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stall_valid[%0d]", s), 32'(vld_w[0]), 32'h0);
            chk($sformatf("stall_hold_data[%0d]", s), 32'(dout_w[0]), 32'h011);
        end
        stall = 1'b0;
        @(negedge clk);
        #1;
        chk("stall_release_pop", 32'(pop_w[0]), 32'b0100);
        run(4);
        check_log("stall", 3, stl_s, stl_d);

        // Reset in the middle of a BURST=4 turn.
        start(2);
        for (int w = 0; w < 5; w++) fq[2].push_back(10'(10'h200 + w));
        refresh();
        release_rst();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst_pre_valid", 32'(vld_w[2]), 32'h1);
        chk("midrst_pre_data", 32'(dout_w[2]), 32'h201);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid_cleared", 32'(vld_w[2]), 32'h0);
        chk("midrst_select_cleared", 32'(sel_w[2]), 32'h0);
        fq[0].push_back(10'h300);
        fq[0].push_back(10'h301);
        refresh();
        clear_logs();
        release_rst();
        #1;
        chk("midrst_first_pop", 32'(pop_w[2]), 32'b0001);
        run(8);
        check_log("midrst", 5, rst_s, rst_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that sits directly upstream of the 4-way demultiplexer in the round-robin path.
- Drains four first-word-fall-through input FIFOs one word per cycle, with an optional burst weight per turn.
- Presents each selected word on a 10-bit data output, together with the 2-bit source index that drives the demux select.
- Back-pressure from downstream freezes arbitration.

Parameters:
- DATA_W, 10, word width; must match the demux data width.
- BURST, 1, consecutive grants a queue may take before rotation (legal 1..8).
- CNT_W, 3, width of the burst counter; must hold the value BURST.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset, 1 = run).
- empty  input  4  empty flag of FIFO i (bit i); FIFO word is valid on data_in_i when empty[i]=0.
- data_in_0  input  DATA_W  head word of FIFO 0.
- data_in_1  input  DATA_W  head word of FIFO 1.
- data_in_2  input  DATA_W  head word of FIFO 2.
- data_in_3  input  DATA_W  head word of FIFO 3.
- stall  input  1  downstream almost-full; 1 blocks all grants this cycle.
- pop  output  4  one-hot read strobe to FIFO i, combinational, same cycle as grant.
- data_out  output  DATA_W  registered granted word.
- select  output  2  registered index of the granted queue, feeds the demux select.
- valid_out  output  1  registered; 1 when data_out/select carry a new word this cycle.

Behaviour:
- Reset:
  - reset=0 asynchronously forces ptr=0, cnt=0, data_out=0, select=0, valid_out=0.
  - pop is forced to 0 while reset=0.
- Internal state:
  - ptr[1:0] is the current holder queue.
  - cnt[CNT_W-1:0] counts grants given to the holder in the current turn.
- Grant decision, combinational, evaluated each cycle with reset=1 and stall=0:
  - Holder ptr non-empty and cnt<BURST: grant g=ptr.
  - Otherwise: search ptr+1, ptr+2, ptr+3 (mod 4) in that order; grant the first non-empty queue g.
  - No queue non-empty: no grant.
- With a grant:
  - pop[g]=1 and all other pop bits 0.
  - At the clock edge: data_out<=data_in_g, select<=g, valid_out<=1.
  - Latency is 1 cycle from pop to valid_out.
- Counter update after a grant:
  - If g==ptr, cnt<=cnt+1; otherwise ptr<=g and cnt<=1.
  - If the post-update count equals BURST, then ptr<=g+1 (mod 4) and cnt<=0 instead.
  - With BURST=1, ptr always advances to g+1 after every grant.
- No grant, or stall=1:
  - pop=0 and valid_out<=0.
  - data_out and select hold their last values.
  - ptr and cnt hold.
- stall is sampled in the same cycle as the grant.
  - A word already registered (valid_out=1) is delivered regardless of stall asserting afterwards.
  - Downstream almost-full thresholds must absorb this 1-word skid.
- At most one pop bit is high in any cycle; pop is never asserted to an empty FIFO.
- Wrap-around: index 3 +1 = 0 for both the search and ptr.
- Simultaneous events:
  - A FIFO becoming non-empty in the same cycle as the search sees the current empty value only; no look-ahead.
  - If the holder empties mid-burst, the turn ends immediately and the next non-empty queue starts a fresh turn.
- Reset asserted mid-burst discards the remaining turn.
  - After release, arbitration restarts from queue 0 with cnt=0.
  - An in-flight valid_out is cleared asynchronously.

Test Plan:
- Reset: reset=0 with all FIFOs non-empty -> pop=4'b0000, valid_out=0, data_out=10'h000, select=0; first cycle after release -> pop=4'b0001.
- Rotation, BURST=1: all four FIFOs hold 2 words (queue i words 10'h0i0, 10'h0i1) -> pop order 0,1,2,3,0,1,2,3; select sequence 0,1,2,3,0,1,2,3 one cycle behind; 8 consecutive valid_out=1.
- Skip empty: only queues 1 and 3 non-empty, ptr=0 -> grants alternate 1,3,1,3; queues 0 and 2 never popped.
- Burst, BURST=3: queue 0 holds 5 words, queue 2 holds 2 -> grants 0,0,0,2,2,0,0; the fourth grant has select=2.
- Stall: assert stall for 3 cycles mid-stream after a grant of queue 1 -> pop=0 and valid_out=0 for those 3 cycles, data_out holds queue 1's word; the first grant after release is queue 2.
- Reset mid-burst, BURST=4: reset pulses low after 2 grants of queue 2 -> valid_out clears immediately; after release the first pop is queue 0 and cnt restarts.
